coproc_bridge: RTL

Parametrised coprocessor bus bridge: the next generation of the processor's 2-bit-addressed coprocessor adapter. It decodes addressed command words from the 32-bit processor bus and queues them in a request FIFO. It dispatches them one at a time to an attached coprocessor module with a start/ready handshake. Each result is posted back onto the bus as an addressed word with a one-cycle interrupt pulse, and an optional watchdog posts an error word if the module never answers.

---
 rtl/coproc_bridge.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/coproc_bridge.sv
// -----------------------------------------------------------------------------
// coproc_bridge
//   Bridge between the 32-bit processor bus and an attached coprocessor
//   module. Commands addressed to this bridge are captured on a rising match
//   and queued in a request FIFO. They are handed to the module one at a time
//   with a start pulse. Each result is posted back on the bus as an addressed
//   word, together with a one-cycle interrupt pulse.
//
//   Optional feature macro: COPROC_TIMEOUT_EN
//     When defined, a watchdog posts an error word if the module does not
//     answer within TIMEOUT cycles of the start.
//
// Ports
//   clk         sole clock, rising edge
//   rst         asynchronous active-low reset
//   devaddrin   address this bridge accepts commands on
//   devaddrout  address stamped into posted results
//   in          bus word: [BUS_W-1] valid, [BUS_W-2 -: ADDR_W] address,
//               [DATA_W-1:0] payload
//   out         last posted word, held until the next post
//   mrdy        module result valid
//   mout        module result
//   min         command payload to the module (registered)
//   mstart      one-cycle start pulse (registered)
//   irq         one-cycle pulse coincident with each post
//   busy        FSM not idle or FIFO non-empty
//   ovf         sticky: a command was dropped on a full FIFO
//   dbg_state   FSM state for observation (0 = IDLE, 1 = WAIT)
//
// Handshake: a command is accepted only on the cycle its match first rises.
// The module sees exactly one mstart per command; it answers by raising mrdy
// with mout valid for at least one cycle while the bridge waits. mrdy is
// sampled on the rising edge and ignored when the bridge is idle.
// -----------------------------------------------------------------------------
module coproc_bridge #(
   parameter int ADDR_W     = 2,
   parameter int DATA_W     = 24,
   parameter int BUS_W      = 32,
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] devaddrin,
   input  logic [ADDR_W-1:0] devaddrout,
   input  logic [BUS_W-1:0]  in,
   output logic [BUS_W-1:0]  out,
   input  logic              mrdy,
   input  logic [DATA_W-1:0] mout,
   output logic [DATA_W-1:0] min,
   output logic              mstart,
   output logic              irq,
   output logic              busy,
   output logic              ovf,
   output logic              dbg_state
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam int GAP_W = BUS_W - DATA_W - ADDR_W - 2;

   // Elaboration-time sanity check of the parameter set.
   if (BUS_W < DATA_W + ADDR_W + 2 || FIFO_DEPTH < 2 ||
       (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_params
      $error("coproc_bridge: illegal parameter combination");
   end

   // Bus bits between the error flag position and the payload carry nothing.
   if (GAP_W > 0) begin : g_gap
      logic unused_gap;
      assign unused_gap = ^in[BUS_W-ADDR_W-3:DATA_W];
   end

   typedef enum logic {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } state_t;

   state_t state, state_d;

   // ---------------------------------------------------------------- decode
   logic match, match_prev, accept;

   assign match  = in[BUS_W-1] && (in[BUS_W-2 -: ADDR_W] == devaddrin);
   assign accept = match && !match_prev;

   // ---------------------------------------------------------------- fifo
   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [CNT_W-1:0]  count;
   logic              empty, full, push, pop, drop;

   assign empty = (count == '0);
   assign full  = (count == CNT_W'(FIFO_DEPTH));
   // A pop on the same edge frees a slot, so a full FIFO can still take a push.
   assign push  = accept && (!full || pop);
   assign drop  = accept && full && !pop;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= in[DATA_W-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // ---------------------------------------------------------------- watchdog
   logic post, post_err;

`ifdef COPROC_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

   logic [WD_W-1:0] wd_cnt;
   logic            wd_expired;

   // The count is cleared on the edge that enters WAIT and advances on every
   // WAIT edge, so expiry lands TIMEOUT edges after entry.
   assign wd_expired = (wd_cnt == WD_LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wd_cnt <= '0;
      end else if (pop) begin
         wd_cnt <= '0;
      end else if (state == S_WAIT) begin
         wd_cnt <= wd_cnt + 1'b1;
      end
   end
`endif

   // ---------------------------------------------------------------- fsm
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_d;
      end
   end

   always_comb begin
      state_d  = state;
      pop      = 1'b0;
      post     = 1'b0;
      post_err = 1'b0;
      case (state)
         S_IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            // A result arriving on the expiry edge takes precedence.
            if (mrdy) begin
               post    = 1'b1;
               state_d = S_IDLE;
            end
`ifdef COPROC_TIMEOUT_EN
            else if (wd_expired) begin
               post     = 1'b1;
               post_err = 1'b1;
               state_d  = S_IDLE;
            end
`endif
         end
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------- post word
   logic [BUS_W-1:0] post_word;

   always_comb begin
      post_word                      = '0;
      post_word[BUS_W-1]             = 1'b1;
      post_word[BUS_W-2 -: ADDR_W]   = devaddrout;
      post_word[BUS_W-2-ADDR_W]      = post_err;
      post_word[DATA_W-1:0]          = post_err ? '0 : mout;
   end

   // ---------------------------------------------------------------- outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         match_prev <= 1'b0;
         ovf        <= 1'b0;
         mstart     <= 1'b0;
         min        <= '0;
         irq        <= 1'b0;
         out        <= '0;
      end else begin
         match_prev <= match;
         if (drop) begin
            ovf <= 1'b1;
         end
         mstart <= pop;
         if (pop) begin
            min <= mem[rd_ptr];
         end
         irq <= post;
         if (post) begin
            out <= post_word;
         end
      end
   end

   assign busy      = (state != S_IDLE) || !empty;
   assign dbg_state = (state == S_WAIT);

endmodule
